floppy_step_gen: RTL and testbench

FLOPPY_STEP_GEN -- requirements
Module: floppy_step_gen

---
 rtl/floppy_step_gen.sv | 147 ++++++++++++++
 tb/tb_floppy_step_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/floppy_step_gen.sv
// Floppy STEP/DIR seek sequencer: DIR setup, N timed STEP pulses, head-settle, then a one-cycle done.
// Optional STEP_TRK0_STOP_EN: an outward seek stops early once TRACK 0 is seen.
module floppy_step_gen #(
  parameter int DIR_SETUP_CLKS = 4,
  parameter int PULSE_CLKS     = 2,
  parameter int STEP_CLKS      = 10,
  parameter int SETTLE_CLKS    = 20,
  parameter int CNT_BITS       = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [CNT_BITS-1:0] cmd_count,
  input  logic                trk0,
  output logic                step_n,
  output logic                dir_n,
  output logic                busy,
  output logic                done,
  output logic                trk0_stop
);

  localparam int MAX_AB = (DIR_SETUP_CLKS > PULSE_CLKS) ? DIR_SETUP_CLKS : PULSE_CLKS;
  localparam int MAX_CD = (STEP_CLKS > SETTLE_CLKS) ? STEP_CLKS : SETTLE_CLKS;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAXP + 1);
  localparam int GAP_CLKS = STEP_CLKS - PULSE_CLKS;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, SETTLE} state_t;

  state_t              state;
  logic [TW-1:0]       tmr;
  logic [CNT_BITS-1:0] remain;
  logic                stop_hit;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef STEP_TRK0_STOP_EN
  logic          trk0_cut;
  logic [TW:0]   settle_sum;
  logic [TW:0]   settle_left;
  assign trk0_cut = trk0 & dir_n;
  // Settle is measured from the last STEP rise, so credit the GAP time already spent.
  assign settle_sum  = {1'b0, tmr} + (TW+1)'(SETTLE_CLKS - 1);
  assign settle_left = settle_sum - (TW+1)'(GAP_CLKS);
`else
  logic unused_trk0;
  assign unused_trk0 = trk0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      remain    <= '0;
      stop_hit  <= 1'b0;
      step_n    <= 1'b1;
      dir_n     <= 1'b1;
      done      <= 1'b0;
      trk0_stop <= 1'b0;
    end else begin
      done      <= 1'b0;
      trk0_stop <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_count == '0) begin
              done <= 1'b1;
            end else begin
              remain   <= cmd_count;
              dir_n    <= ~cmd_dir;
              tmr      <= TW'(DIR_SETUP_CLKS - 1);
              stop_hit <= 1'b0;
              state    <= SETUP;
            end
          end
        end
        SETUP: begin
`ifdef STEP_TRK0_STOP_EN
          if (trk0_cut) begin
            stop_hit <= 1'b1;
            tmr      <= TW'(SETTLE_CLKS - 1);
            state    <= SETTLE;
          end else
`endif
          if (tmr == '0) begin
            step_n <= 1'b0;
            tmr    <= TW'(PULSE_CLKS - 1);
            state  <= PULSE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            step_n <= 1'b1;
            remain <= remain - 1'b1;
            if (remain == CNT_BITS'(1)) begin
              tmr   <= TW'(SETTLE_CLKS - 1);
              state <= SETTLE;
            end else begin
              tmr   <= TW'(GAP_CLKS - 1);
              state <= GAP;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GAP: begin
`ifdef STEP_TRK0_STOP_EN
          if (trk0_cut) begin
            stop_hit <= 1'b1;
            if (settle_sum >= (TW+1)'(GAP_CLKS)) begin
              tmr   <= settle_left[TW-1:0];
              state <= SETTLE;
            end else begin
              done      <= 1'b1;
              trk0_stop <= 1'b1;
              state     <= IDLE;
            end
          end else
`endif
          if (tmr == '0) begin
            step_n <= 1'b0;
            tmr    <= TW'(PULSE_CLKS - 1);
            state  <= PULSE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            done      <= 1'b1;
            trk0_stop <= stop_hit;
            state     <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floppy_step_gen.sv
// Bench for floppy_step_gen: table vectors, hand-written reset/trk0 sequences, randomized seeks vs a timing model.
module tb_floppy_step_gen;

  localparam int D = 4, P = 2, S = 10, T = 20, CB = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CB-1:0] cmd_count = '0;
  logic          trk0 = 1'b0;
  logic          step_n, dir_n, busy, done, trk0_stop;

  int checks = 0;
  int errors = 0;
  logic exp_dirn = 1'b1;

  always #5 clk = ~clk;

  floppy_step_gen #(.DIR_SETUP_CLKS(D), .PULSE_CLKS(P), .STEP_CLKS(S),
                    .SETTLE_CLKS(T), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .trk0(trk0), .step_n(step_n),
    .dir_n(dir_n), .busy(busy), .done(done), .trk0_stop(trk0_stop));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a seek of n steps is a list of low windows and a done offset, relative to the accept edge.
  function automatic logic exp_step(input int c, input int n);
    for (int k = 0; k < n; k++)
      if (c >= D + k*S && c < D + k*S + P) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int done_at(input int n);
    return (n == 0) ? 0 : D + (n-1)*S + P + T;
  endfunction

  typedef struct {
    logic dir;
    int   count;
    int   exp_pulses;
    int   exp_done;
    logic exp_dirn;
  } vec_t;

  vec_t vecs[4];

  // Applies one table entry and records what the pins did over a fixed window.
  task automatic apply_vec(input vec_t v, input int idx);
    int nfalls, low_cycles, done_c, ndone;
    logic prev;
    nfalls = 0; low_cycles = 0; done_c = -1; ndone = 0; prev = 1'b1;
    cmd_valid = 1'b1; cmd_dir = v.dir; cmd_count = CB'(v.count);
    @(posedge clk);
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (prev && !step_n) begin
        chk($sformatf("v%0d_fall%0d_pos", idx, nfalls), c, D + nfalls*S);
        nfalls++;
      end
      if (!step_n) low_cycles++;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (c == 0) chk($sformatf("v%0d_dirn", idx), dir_n, v.exp_dirn);
      prev = step_n;
    end
    chk($sformatf("v%0d_pulses", idx), nfalls, v.exp_pulses);
    chk($sformatf("v%0d_lowcycles", idx), low_cycles, v.exp_pulses * P);
    chk($sformatf("v%0d_done_at", idx), done_c, v.exp_done);
    chk($sformatf("v%0d_done_once", idx), ndone, 1);
    chk($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
    if (v.count != 0) exp_dirn = ~v.dir;
  endtask

  // Random seek; unrelated command attempts while busy must have no effect.
  task automatic run_cmd(input logic dir, input int n);
    int dc;
    dc = done_at(n);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_count = CB'(n);
    @(posedge clk);
    if (n != 0) exp_dirn = ~dir;
    for (int c = 0; c <= dc; c++) begin
      @(negedge clk);
      chk("rnd_step_n", step_n, exp_step(c, n));
      chk("rnd_done", done, (c == dc) ? 1 : 0);
      chk("rnd_busy", busy, (c < dc) ? 1 : 0);
      chk("rnd_ready", cmd_ready, (c < dc) ? 0 : 1);
      chk("rnd_dir_n", dir_n, exp_dirn);
      chk("rnd_trk0_stop", trk0_stop, 0);
      if (c < dc) begin
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_dir   = 1'($urandom);
        cmd_count = CB'($urandom);
`ifndef STEP_TRK0_STOP_EN
        trk0      = 1'($urandom);
`endif
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{dir: 1'b1, count: 3, exp_pulses: 3, exp_done: 46, exp_dirn: 1'b0};
    vecs[1] = '{dir: 1'b1, count: 0, exp_pulses: 0, exp_done: 0,  exp_dirn: 1'b0};
    vecs[2] = '{dir: 1'b0, count: 1, exp_pulses: 1, exp_done: 26, exp_dirn: 1'b1};
    vecs[3] = '{dir: 1'b1, count: 2, exp_pulses: 2, exp_done: 36, exp_dirn: 1'b0};

    // Held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_step_n", step_n, 1);
    chk("rst_dir_n", dir_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_trk0_stop", trk0_stop, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Reset while STEP is low: pin must release without a clock edge, and no done afterwards.
    begin
      int ndone;
      ndone = 0;
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = CB'(2);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && step_n; i++) @(negedge clk);
      chk("mid_reached_low", step_n, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_step_n", step_n, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dir_n", dir_n, 1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_dirn = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("mid_no_done", ndone, 0);
      chk("mid_ready", cmd_ready, 1);
      chk("mid_step_n_idle", step_n, 1);
    end

`ifdef STEP_TRK0_STOP_EN
    // Outward seek of 10, TRACK 0 appears right after the 2nd pulse ends.
    begin
      int nfalls, done_c, stop_at_done;
      logic prev;
      nfalls = 0; done_c = -1; stop_at_done = 0; prev = 1'b1;
      cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = CB'(10);
      @(posedge clk);
      for (int c = 0; c <= 80; c++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (prev && !step_n) nfalls++;
        if (done && done_c < 0) begin
          done_c = c;
          stop_at_done = trk0_stop;
        end
        if (c == D + S + P) trk0 = 1'b1;
        prev = step_n;
      end
      trk0 = 1'b0;
      chk("trk0_pulses", nfalls, 2);
      chk("trk0_done_at", done_c, D + S + P + T);
      chk("trk0_stop_flag", stop_at_done, 1);
      exp_dirn = 1'b1;
    end
`endif

    for (int i = 0; i < 40; i++)
      run_cmd(1'($urandom), $urandom_range(0, 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
